key_cursor_ctrl: RTL and testbench

KEY_CURSOR_CTRL -- requirements
Module: key_cursor_ctrl

---
 rtl/key_pkg.sv | 42 ++++
 rtl/key_cmd_decode.sv | 23 ++
 rtl/key_cursor_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_key_cursor_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// key_pkg: scancodes, decoded command set and repeat-FSM states shared by
// the cursor controller and its scancode decoder.
package key_pkg;

  localparam logic [7:0] SC_NONE    = 8'h00;
  localparam logic [7:0] SC_UP_A    = 8'h1D;
  localparam logic [7:0] SC_UP_B    = 8'h43;
  localparam logic [7:0] SC_DOWN_A  = 8'h1B;
  localparam logic [7:0] SC_DOWN_B  = 8'h42;
  localparam logic [7:0] SC_LEFT_A  = 8'h1C;
  localparam logic [7:0] SC_LEFT_B  = 8'h33;
  localparam logic [7:0] SC_RIGHT_A = 8'h23;
  localparam logic [7:0] SC_RIGHT_B = 8'h4B;
  localparam logic [7:0] SC_SEL     = 8'h29;
  localparam logic [7:0] SC_ALT     = 8'h34;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_UP    = 3'd1,
    CMD_DOWN  = 3'd2,
    CMD_LEFT  = 3'd3,
    CMD_RIGHT = 3'd4,
    CMD_SEL   = 3'd5,
    CMD_ALT   = 3'd6
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  function automatic logic cmd_is_dir(input cmd_t c);
    logic r;
    case (c)
      CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT: r = 1'b1;
      default:                               r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_cmd_decode.sv
// key_cmd_decode: purely combinational scancode to command translation.
module key_cmd_decode
  import key_pkg::*;
(
  input  logic [7:0] code,
  output cmd_t       cmd
);

  // Two scancodes per direction so both keypad and letter clusters steer.
  always_comb begin
    cmd = CMD_NONE;
    case (code)
      SC_UP_A,    SC_UP_B:    cmd = CMD_UP;
      SC_DOWN_A,  SC_DOWN_B:  cmd = CMD_DOWN;
      SC_LEFT_A,  SC_LEFT_B:  cmd = CMD_LEFT;
      SC_RIGHT_A, SC_RIGHT_B: cmd = CMD_RIGHT;
      SC_SEL:                 cmd = CMD_SEL;
      SC_ALT:                 cmd = CMD_ALT;
      default:                cmd = CMD_NONE;
    endcase
  end

endmodule

// File: rtl/key_cursor_ctrl.sv
// key_cursor_ctrl: PS/2 key events drive a grid cursor plus select/alt pulses.
// Build option: define KEY_REPEAT_EN to compile in hold-to-auto-repeat.
module key_cursor_ctrl
  import key_pkg::*;
#(
  parameter int COLS          = 8,
  parameter int ROWS          = 8,
  parameter int WRAP          = 1,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [10:0]             key_event,
  input  logic                    lock,
  output logic [$clog2(COLS)-1:0] cursor_x,
  output logic [$clog2(ROWS)-1:0] cursor_y,
  output logic                    sel_pulse,
  output logic                    alt_pulse,
  output logic                    move_pulse
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);

  logic            ev_valid_s;
  logic            ev_break_s;
  logic [7:0]      ev_code_s;
  logic            make_s;
  logic            brk_s;
  cmd_t            cmd_s;
  logic            is_dir_s;
  logic            rep_fire_s;
  cmd_t            rep_cmd_s;
  cmd_t            mv_cmd_s;
  logic [XW-1:0]   x_nx_s;
  logic [YW-1:0]   y_nx_s;
  logic            unused_ok_s;

  logic [7:0]      held_code_d, held_code_q;
  logic [XW-1:0]   x_d, x_q;
  logic [YW-1:0]   y_d, y_q;
  logic            sel_d, sel_q;
  logic            alt_d, alt_q;
  logic            move_d, move_q;

  assign ev_valid_s  = key_event[10];
  assign ev_break_s  = key_event[8];
  assign ev_code_s   = key_event[7:0];
  // The receiver holds its last event, so a make counts only when it differs from the held key.
  assign make_s      = ev_valid_s & ~ev_break_s & (ev_code_s != held_code_q);
  assign brk_s       = ev_valid_s &  ev_break_s & (ev_code_s == held_code_q);
  assign is_dir_s    = cmd_is_dir(cmd_s);
  assign unused_ok_s = ^{key_event[9], REPEAT_DELAY[0], REPEAT_PERIOD[0]};

  key_cmd_decode u_decode (
    .code (ev_code_s),
    .cmd  (cmd_s)
  );

  // Widened to 5 bits so n-1 never overflows for any legal grid size.
  function automatic logic [4:0] step(input logic [4:0] v, input logic [4:0] n,
                                      input logic inc);
    logic [4:0] r;
    if (inc) begin
      if (v == n - 5'd1) r = (WRAP != 0) ? 5'd0 : v;
      else               r = v + 5'd1;
    end else begin
      if (v == 5'd0)     r = (WRAP != 0) ? n - 5'd1 : v;
      else               r = v - 5'd1;
    end
    return r;
  endfunction

`ifdef KEY_REPEAT_EN
  localparam int MAXC = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

  rep_state_t    state_q;
  logic [CW-1:0] cnt_q;
  cmd_t          rep_dir_q;

  // A repeat fires on counter expiry unless lock, a break or a new make claims this cycle.
  always_comb begin
    rep_fire_s = 1'b0;
    rep_cmd_s  = rep_dir_q;
    if (lock || brk_s || make_s) begin
      rep_fire_s = 1'b0;
    end else begin
      case (state_q)
        ST_DELAY:  rep_fire_s = (cnt_q == DLY_LAST);
        ST_REPEAT: rep_fire_s = (cnt_q == PER_LAST);
        default:   rep_fire_s = 1'b0;
      endcase
    end
  end

  // Repeat FSM: the counter restarts on every state transition.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rep_dir_q <= CMD_NONE;
    end else if (lock || brk_s) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (make_s) begin
      cnt_q <= '0;
      if (is_dir_s) begin
        state_q   <= ST_DELAY;
        rep_dir_q <= cmd_s;
      end else begin
        state_q <= ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_DELAY: begin
          if (cnt_q == DLY_LAST) begin
            state_q <= ST_REPEAT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (cnt_q == PER_LAST) cnt_q <= '0;
          else                   cnt_q <= cnt_q + 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end
`else
  assign rep_fire_s = 1'b0;
  assign rep_cmd_s  = CMD_NONE;
`endif

  // Next-state for held key, cursor and the three pulses.
  always_comb begin
    if (make_s)     held_code_d = ev_code_s;
    else if (brk_s) held_code_d = SC_NONE;
    else            held_code_d = held_code_q;

    if (make_s && !lock && is_dir_s) mv_cmd_s = cmd_s;
    else if (rep_fire_s)             mv_cmd_s = rep_cmd_s;
    else                             mv_cmd_s = CMD_NONE;

    x_nx_s = x_q;
    y_nx_s = y_q;
    case (mv_cmd_s)
      CMD_UP:    y_nx_s = YW'(step(5'(y_q), 5'(ROWS), 1'b0));
      CMD_DOWN:  y_nx_s = YW'(step(5'(y_q), 5'(ROWS), 1'b1));
      CMD_LEFT:  x_nx_s = XW'(step(5'(x_q), 5'(COLS), 1'b0));
      CMD_RIGHT: x_nx_s = XW'(step(5'(x_q), 5'(COLS), 1'b1));
      default: begin
        x_nx_s = x_q;
        y_nx_s = y_q;
      end
    endcase

    x_d    = x_nx_s;
    y_d    = y_nx_s;
    move_d = (x_nx_s != x_q) || (y_nx_s != y_q);
    sel_d  = make_s && !lock && (cmd_s == CMD_SEL);
    alt_d  = make_s && !lock && (cmd_s == CMD_ALT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      held_code_q <= SC_NONE;
      x_q         <= '0;
      y_q         <= '0;
      sel_q       <= 1'b0;
      alt_q       <= 1'b0;
      move_q      <= 1'b0;
    end else begin
      held_code_q <= held_code_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sel_q       <= sel_d;
      alt_q       <= alt_d;
      move_q      <= move_d;
    end
  end

  assign cursor_x   = x_q;
  assign cursor_y   = y_q;
  assign sel_pulse  = sel_q;
  assign alt_pulse  = alt_q;
  assign move_pulse = move_q;

endmodule

// File: tb/tb_key_cursor_ctrl.sv
// Bench: a wrapping and a clamping instance share stimulus and are checked
// every cycle against a rule-level model; directed scenarios then random keys.
module tb_key_cursor_ctrl;

  localparam int COLS = 5;
  localparam int ROWS = 3;
  localparam int RD   = 10;
  localparam int RP   = 4;
`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [10:0] key_event = 11'd0;
  logic        lock = 1'b0;
  logic [2:0]  xw, xc;
  logic [1:0]  yw, yc;
  logic        sel_w, alt_w, mv_w, sel_c, alt_c, mv_c;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_held;
  int  m_xw, m_yw, m_xc, m_yc;
  bit  e_sel, e_alt, e_mvw, e_mvc;
  bit  rep_on;
  int  rep_d, t0, cyc;
  int  n_mv_w, n_mv_c, n_sel, n_alt;

  logic [7:0] codes [12] = '{8'h1D, 8'h43, 8'h1B, 8'h42, 8'h1C, 8'h33,
                             8'h23, 8'h4B, 8'h29, 8'h34, 8'h15, 8'h1B};

  key_cursor_ctrl #(.COLS(COLS), .ROWS(ROWS), .WRAP(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
  dut_wrap (.clk(clk), .rstn(rstn), .key_event(key_event), .lock(lock),
            .cursor_x(xw), .cursor_y(yw), .sel_pulse(sel_w), .alt_pulse(alt_w),
            .move_pulse(mv_w));

  key_cursor_ctrl #(.COLS(COLS), .ROWS(ROWS), .WRAP(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
  dut_clamp (.clk(clk), .rstn(rstn), .key_event(key_event), .lock(lock),
             .cursor_x(xc), .cursor_y(yc), .sel_pulse(sel_c), .alt_pulse(alt_c),
             .move_pulse(mv_c));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] c);
    return {1'b1, 1'b0, 1'b0, c};
  endfunction

  function automatic logic [10:0] bk(input logic [7:0] c);
    return {1'b1, 1'b0, 1'b1, c};
  endfunction

  // 1 up, 2 down, 3 left, 4 right, 0 not a direction
  function automatic int dir_of(input logic [7:0] c);
    case (c)
      8'h1D, 8'h43: return 1;
      8'h1B, 8'h42: return 2;
      8'h1C, 8'h33: return 3;
      8'h23, 8'h4B: return 4;
      default:      return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_held = 8'h00;
    m_xw = 0; m_yw = 0; m_xc = 0; m_yc = 0;
    e_sel = 0; e_alt = 0; e_mvw = 0; e_mvc = 0;
    rep_on = 0; rep_d = 0; t0 = 0;
  endtask

  // Expected state after the coming clock edge, given the inputs at that edge.
  task automatic model_step(input logic [10:0] ke, input logic lk);
    logic [7:0] code;
    bit mk_a, bk_a;
    int mv, el, oxw, oyw, oxc, oyc;
    code = ke[7:0];
    cyc++;
    mk_a = ke[10] && !ke[8] && (code != m_held);
    bk_a = ke[10] &&  ke[8] && (code == m_held);
    e_sel = 0; e_alt = 0; mv = 0;
    if (mk_a) begin
      m_held = code;
      if (!lk && dir_of(code) != 0) begin
        mv = dir_of(code); rep_on = 1; rep_d = mv; t0 = cyc;
      end else begin
        rep_on = 0;
      end
      e_sel = !lk && (code == 8'h29);
      e_alt = !lk && (code == 8'h34);
    end else if (bk_a) begin
      m_held = 8'h00; rep_on = 0;
    end else if (lk) begin
      rep_on = 0;
    end else if (rep_on && REP_EN) begin
      el = cyc - t0;
      if (el >= RD && ((el - RD) % RP) == 0) mv = rep_d;
    end
    oxw = m_xw; oyw = m_yw; oxc = m_xc; oyc = m_yc;
    case (mv)
      1: begin m_yw = (m_yw + ROWS - 1) % ROWS; m_yc = (m_yc > 0) ? m_yc - 1 : 0; end
      2: begin m_yw = (m_yw + 1) % ROWS; m_yc = (m_yc < ROWS - 1) ? m_yc + 1 : m_yc; end
      3: begin m_xw = (m_xw + COLS - 1) % COLS; m_xc = (m_xc > 0) ? m_xc - 1 : 0; end
      4: begin m_xw = (m_xw + 1) % COLS; m_xc = (m_xc < COLS - 1) ? m_xc + 1 : m_xc; end
      default: ;
    endcase
    e_mvw = (m_xw != oxw) || (m_yw != oyw);
    e_mvc = (m_xc != oxc) || (m_yc != oyc);
  endtask

  task automatic check_all();
    check("x_wrap", xw, m_xw);
    check("y_wrap", yw, m_yw);
    check("x_clamp", xc, m_xc);
    check("y_clamp", yc, m_yc);
    check("move_wrap", mv_w, e_mvw);
    check("move_clamp", mv_c, e_mvc);
    check("sel_wrap", sel_w, e_sel);
    check("sel_clamp", sel_c, e_sel);
    check("alt_wrap", alt_w, e_alt);
    check("alt_clamp", alt_c, e_alt);
  endtask

  task automatic cyc_step(input logic [10:0] ke, input logic lk);
    @(negedge clk);
    key_event = ke;
    lock = lk;
    model_step(ke, lk);
    @(posedge clk);
    #1;
    check_all();
    n_mv_w += int'(mv_w);
    n_mv_c += int'(mv_c);
    n_sel  += int'(sel_w);
    n_alt  += int'(alt_w);
  endtask

  task automatic hold(input logic [10:0] ke, input logic lk, input int n);
    for (int i = 0; i < n; i++) cyc_step(ke, lk);
  endtask

  task automatic clr_counts();
    n_mv_w = 0; n_mv_c = 0; n_sel = 0; n_alt = 0;
  endtask

  // Asserts reset between edges and expects outputs to clear without a clock.
  task automatic async_reset();
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    key_event = 11'd0;
    lock = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int sel, len;
    logic [7:0] code;
    logic lk;
    logic [10:0] ke;

    cyc = 0;
    clr_counts();
    async_reset();

    // single right press from reset
    hold(mk(8'h23), 1'b0, 3);
    hold(bk(8'h23), 1'b0, 1);
    hold(11'd0, 1'b0, 2);
    check("r35_moves", n_mv_w, 1);
    check("r35_x", xw, 1);

    // walk to the right edge, then one more step
    for (int i = 0; i < 3; i++) begin
      hold(mk(8'h23), 1'b0, 1);
      hold(bk(8'h23), 1'b0, 1);
    end
    check("r36_pre_x", xw, 4);
    clr_counts();
    hold(mk(8'h4B), 1'b0, 1);
    check("r36_wrap_x", xw, 0);
    check("r36_clamp_x", xc, 4);
    check("r36_wrap_moves", n_mv_w, 1);
    check("r36_clamp_moves", n_mv_c, 0);
    hold(bk(8'h4B), 1'b0, 1);

    // hold down for 25 cycles
    clr_counts();
    hold(mk(8'h1B), 1'b0, 25);
    check("r37_wrap_moves", n_mv_w, REP_EN ? 5 : 1);
    check("r37_wrap_y", yw, REP_EN ? 2 : 1);
    check("r37_clamp_moves", n_mv_c, REP_EN ? 2 : 1);
    check("r37_clamp_y", yc, REP_EN ? 2 : 1);
    hold(bk(8'h1B), 1'b0, 2);

    // select never repeats; alt suppressed under lock
    clr_counts();
    hold(mk(8'h29), 1'b0, 20);
    check("r38_sel_count", n_sel, 1);
    hold(bk(8'h29), 1'b0, 1);
    hold(mk(8'h34), 1'b1, 5);
    check("r38_alt_locked", n_alt, 0);
    hold(bk(8'h34), 1'b1, 1);
    hold(11'd0, 1'b0, 1);

    // reset while repeating left
    hold(mk(8'h1C), 1'b0, 12);
    async_reset();
    clr_counts();
    hold(11'd0, 1'b0, 15);
    check("r39_moves_after", n_mv_w + n_mv_c, 0);
    check("r39_x", xw, 0);

    // random key traffic
    for (int ev = 0; ev < 60; ev++) begin
      sel  = $urandom_range(0, 99);
      len  = $urandom_range(1, 14);
      code = codes[$urandom_range(0, 11)];
      lk   = ($urandom_range(0, 7) == 0);
      if (sel < 60)      ke = mk(code);
      else if (sel < 78) ke = bk(m_held);
      else if (sel < 88) ke = bk(code);
      else               ke = 11'd0;
      hold(ke, lk, len);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
